alu_arbiter: RTL

Shares the single combinational `alu` (32-bit operands A/B, 4-bit operation, 64-bit result C) between two requesters, such as the control-unit datapath and a debug/test port. It round-robin arbitrates, holds the granted operands stable on the ALU inputs for an opcode-dependent number of cycles (the multiplier is a multicycle path), and registers the 64-bit result. It returns that result on a valid/ready response channel tagged with the requester id.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_arbiter_rr_arb2.sv | 28 ++
 rtl/alu_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU arbiter slice.
//   - Opcode constants the arbiter needs to know about (only OP_MUL changes
//     arbiter timing; the others are listed for the requesters' benefit).
//   - Default settle-cycle counts and the settle counter width.
//   - FSM state encoding for the arbiter.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b1111;

  // The multiplier inside the ALU is a multicycle path; everything else
  // settles in a single cycle.
  localparam int MUL_CYCLES_DEF  = 4;
  localparam int BASE_CYCLES_DEF = 1;

  // Settle counter width; cycle counts are limited to 1..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2
//   Two-way round-robin grant, purely combinational.
//   Ports:
//     req_valid [1:0]  in   per-requester request valid
//     last_id          in   requester that owned the most recent response
//     gnt_valid        out  at least one requester is asking
//     gnt_id           out  chosen requester (meaningful when gnt_valid)
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last_id,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // On a tie the requester that was not served last wins, so two
  // continuously-valid requesters alternate. With a single requester the
  // grant simply follows it.
  always_comb begin
    gnt_valid = |req_valid;
    gnt_id    = 1'b0;
    if (req_valid == 2'b11) begin
      gnt_id = ~last_id;
    end else if (req_valid[1]) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. A request is
//   accepted in IDLE, its operands are held on the ALU inputs for an
//   opcode-dependent number of cycles (the multiplier is multicycle), the
//   64-bit result is registered and returned on a valid/ready channel
//   tagged with the owning requester.
//   Ports:
//     clk, rst_n        clock (rising edge) and async active-low reset
//     req_valid/ready   per-requester request handshake (bit i = requester i)
//     req_a/b/op        per-requester payload, requester i in slice i
//     rsp_valid/ready   response handshake
//     rsp_id, rsp_c     response owner and registered ALU result
//     alu_a/b/op        operands/opcode to the shared ALU
//     alu_c             result from the shared ALU
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int OP_W        = 4,
  parameter int MUL_CYCLES  = MUL_CYCLES_DEF,
  parameter int BASE_CYCLES = BASE_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [2*OP_W-1:0]   req_op,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [2*DATA_W-1:0] rsp_c,

  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_op,
  input  logic [2*DATA_W-1:0] alu_c
);

  arb_state_t state_q, state_d;

  logic [DATA_W-1:0]   hold_a;
  logic [DATA_W-1:0]   hold_b;
  logic [OP_W-1:0]     hold_op;
  logic                hold_id;
  logic [CNT_W-1:0]    cnt_q;
  logic                last_id_q;
  logic [2*DATA_W-1:0] rsp_c_q;
  logic                rsp_id_q;

  logic                gnt_valid;
  logic                gnt_id;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [OP_W-1:0]     sel_op;

  logic                accept;
  logic                capture;
  logic                rsp_fire;

  // Number of cycles the operands must sit on the ALU before the result is
  // trusted. Unknown opcodes are treated like any single-cycle operation.
  function automatic logic [CNT_W-1:0] settle_cycles(input logic [OP_W-1:0] op);
    if (op == OP_W'(OP_MUL)) begin
      return CNT_W'(MUL_CYCLES);
    end
    return CNT_W'(BASE_CYCLES);
  endfunction

  rr_arb2 u_arb (
    .req_valid (req_valid),
    .last_id   (last_id_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Payload of whichever requester the arbiter is currently pointing at.
  always_comb begin
    sel_a  = gnt_id ? req_a[DATA_W +: DATA_W] : req_a[0 +: DATA_W];
    sel_b  = gnt_id ? req_b[DATA_W +: DATA_W] : req_b[0 +: DATA_W];
    sel_op = gnt_id ? req_op[OP_W +: OP_W]    : req_op[0 +: OP_W];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs. req_ready is only ever raised in IDLE,
  // so a new operation cannot be accepted until the previous response has
  // been taken by the consumer.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    rsp_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          req_ready = gnt_id ? 2'b10 : 2'b01;
          accept    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Hold registers and settle counter. The hold registers drive the ALU
  // directly, so the operands stay frozen for the whole EXEC window and the
  // multicycle multiplier path sees stable inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_a  <= '0;
      hold_b  <= '0;
      hold_op <= '0;
      hold_id <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      hold_a  <= sel_a;
      hold_b  <= sel_b;
      hold_op <= sel_op;
      hold_id <= gnt_id;
      cnt_q   <= settle_cycles(sel_op) - CNT_W'(1);
    end else if (state_q == EXEC && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Response registers. They only load on the final EXEC cycle, so they stay
  // put for as long as the consumer stalls in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_c_q  <= '0;
      rsp_id_q <= 1'b0;
    end else if (capture) begin
      rsp_c_q  <= alu_c;
      rsp_id_q <= hold_id;
    end
  end

  // Fairness pointer. It advances only when a response is actually handed
  // over; starting at 1 lets requester 0 win the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id_q <= 1'b1;
    end else if (rsp_fire) begin
      last_id_q <= rsp_id_q;
    end
  end

  assign alu_a  = hold_a;
  assign alu_b  = hold_b;
  assign alu_op = hold_op;
  assign rsp_c  = rsp_c_q;
  assign rsp_id = rsp_id_q;

endmodule
